// File: rtl/boot_loader.sv
// boot_loader: length-prefixed program loader.
// Accepts a header word N followed by N data words on a valid/ready stream,
// writes them to RAM from address 0, then holds the CPU in reset (clock gated)
// for RESET_HOLD cycles before releasing it. A reload pulse in RUN restarts
// loading; an oversized header parks the loader in a sticky error state.
// Optional build macro BOOT_LOADER_ZERO_FILL_EN: after the image, zero the
// remaining words N..MEM_DEPTH-1 before releasing the CPU.
module boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_reset,
    output logic                  cpu_clk_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word counter is one bit wider than the address so N == 2**ADDR_WIDTH fits.
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int CMP_W  = ((DATA_WIDTH > CNT_W) ? DATA_WIDTH : CNT_W) + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
`ifdef BOOT_LOADER_ZERO_FILL_EN
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(MEM_DEPTH);
`endif

`ifdef BOOT_LOADER_ZERO_FILL_EN
    typedef enum logic [2:0] {ST_LEN, ST_LOAD, ST_FILL, ST_HOLD, ST_RUN, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_LEN, ST_LOAD, ST_HOLD, ST_RUN, ST_ERR} state_t;
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    accept;
    logic                    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_d;

    // Header check done at a width wide enough for both operands.
    function automatic logic len_too_long(input logic [DATA_WIDTH-1:0] n);
        return CMP_W'(n) > CMP_W'(MEM_DEPTH);
    endfunction

    // Where to go once the last image word (or an empty header) is taken;
    // words_written is the count of words already in RAM.
    function automatic state_t after_image(input logic [CNT_W-1:0] words_written);
`ifdef BOOT_LOADER_ZERO_FILL_EN
        return (words_written == DEPTH_C) ? ST_HOLD : ST_FILL;
`else
        return (words_written == words_written) ? ST_HOLD : ST_HOLD;
`endif
    endfunction

    assign accept = in_valid && in_ready;

    // Next-state, counters and the RAM write stage.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        hold_d     = hold_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr;
        mem_data_d = mem_data;
        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    cnt_d  = '0;
                    hold_d = '0;
                    if (len_too_long(in_data)) begin
                        state_d = ST_ERR;
                    end else if (in_data == '0) begin
                        state_d = after_image('0);
                    end else begin
                        len_d   = CNT_W'(in_data);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    mem_data_d = in_data;
                    cnt_d      = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        hold_d  = '0;
                        state_d = after_image(cnt_q + CNT_ONE);
                    end
                end
            end
`ifdef BOOT_LOADER_ZERO_FILL_EN
            ST_FILL: begin
                mem_we_d   = 1'b1;
                mem_addr_d = cnt_q[ADDR_WIDTH-1:0];
                mem_data_d = '0;
                cnt_d      = cnt_q + CNT_ONE;
                if (cnt_q == DEPTH_C - CNT_ONE) begin
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_LEN;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_LEN;
            end
        endcase
    end

    // State, counters and all outputs registered; status outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LEN;
            cnt_q      <= '0;
            len_q      <= '0;
            hold_q     <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_reset  <= 1'b1;
            cpu_clk_en <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            in_ready   <= (state_d == ST_LEN) || (state_d == ST_LOAD);
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_data   <= mem_data_d;
            cpu_reset  <= (state_d != ST_RUN);
            cpu_clk_en <= (state_d == ST_RUN);
            busy       <= (state_d != ST_RUN) && (state_d != ST_ERR);
            done       <= (state_d == ST_RUN);
            error      <= (state_d == ST_ERR);
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized scoreboard bench for boot_loader.
// The driver pushes the expected RAM writes of each image into a queue; a
// negedge monitor pops and compares whenever mem_we is seen.
module tb_boot_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int HOLD  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          cpu_reset;
    logic          cpu_clk_en;
    logic          busy;
    logic          done;
    logic          error;

    boot_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .RESET_HOLD (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .cpu_reset  (cpu_reset),
        .cpu_clk_en (cpu_clk_en),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every RAM write must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {28'b0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {28'b0, mem_addr}, {28'b0, e.a});
                chk("wr_data", {24'b0, mem_data}, {24'b0, e.d});
            end
        end
    end

    // Reference model: an image of n words writes word i to address i; with
    // zero fill the rest of memory is cleared. Returns cycles from the last
    // accepted word until the CPU leaves reset.
    function automatic int model_push(input int n, input logic [DW-1:0] w[$]);
        int  lat;
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.a = AW'(i);
            e.d = w[i];
            exp_q.push_back(e);
        end
        lat = HOLD;
`ifdef BOOT_LOADER_ZERO_FILL_EN
        for (int a = n; a < DEPTH; a++) begin
            e.a = AW'(a);
            e.d = '0;
            exp_q.push_back(e);
        end
        lat = lat + (DEPTH - n);
`endif
        return lat;
    endfunction

    task automatic send_word(input logic [DW-1:0] w);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("accept_timeout", t, 0);
            in_valid = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic bubbles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = DW'($urandom);
        end
    endtask

    task automatic wait_release(input int lat);
        int n;
        n = 0;
        #1;
        in_valid = 1'b0;
        while (cpu_reset !== 1'b0 && n < lat + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("release_cycles", n, lat);
        chk("run_done", done, 1);
        chk("run_clk_en", cpu_clk_en, 1);
        chk("run_busy", busy, 0);
        chk("run_in_ready", in_ready, 0);
        chk("writes_left", exp_q.size(), 0);
    endtask

    task automatic run_image(input int n, input int bmin, input int bmax, input logic [DW-1:0] w[$]);
        int lat;
        lat = model_push(n, w);
        send_word(DW'(n));
        for (int i = 0; i < n; i++) begin
            if (bmax > 0) bubbles($urandom_range(bmax, bmin));
            send_word(w[i]);
        end
        wait_release(lat);
    endtask

    task automatic rand_image(input int n, input int bmax);
        logic [DW-1:0] w[$];
        w = {};
        for (int i = 0; i < n; i++) w.push_back(DW'($urandom));
        run_image(n, 0, bmax, w);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_done", done, 0);
        chk("reload_cpu_reset", cpu_reset, 1);
        chk("reload_clk_en", cpu_clk_en, 0);
        chk("reload_in_ready", in_ready, 1);
        chk("reload_busy", busy, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, {28'b0, mem_addr}, 0);
        chk({tag, "_mem_data"}, {24'b0, mem_data}, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_cpu_clk_en"}, cpu_clk_en, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w[$];
        int            viol;

        reset    = 1'b1;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Scenario 1: back-to-back image.
        w = {8'hA1, 8'hB2, 8'hC3};
        run_image(3, 0, 0, w);

        // Stream input is ignored while running.
        viol = 0;
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            if (in_ready !== 1'b0 || done !== 1'b1) viol++;
        end
        in_valid = 1'b0;
        chk("run_ignores_stream", viol, 0);

        // Scenario 2: three-cycle bubbles between words.
        do_reload();
        w = {8'h11, 8'h22};
        run_image(2, 3, 3, w);

        // Scenario 3: oversized header.
        do_reload();
        send_word(8'h11);
        #1;
        viol = 0;
        repeat (50) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            reload   = 1'($urandom);
            @(posedge clk);
            #1;
            if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1 ||
                cpu_clk_en !== 1'b0 || busy !== 1'b0) viol++;
        end
        in_valid = 1'b0;
        reload   = 1'b0;
        chk("err_sticky", viol, 0);
        chk("err_flag", error, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("err_rst");
        reset = 1'b0;

        // Scenario 4: empty image.
        w = {};
        run_image(0, 0, 0, w);

        // Scenario 5: reset in the middle of a load.
        do_reload();
        w = {8'h3C, 8'h4D};
        void'(model_push(2, w));
`ifdef BOOT_LOADER_ZERO_FILL_EN
        exp_q = exp_q[0:1];
`endif
        send_word(8'd4);
        send_word(8'h3C);
        send_word(8'h4D);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        chk("midload_in_ready", in_ready, 0);
        chk("midload_cpu_reset", cpu_reset, 1);
        chk("midload_busy", busy, 1);
        chk("midload_mem_we", mem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("midload_writes", exp_q.size(), 0);
        w = {8'h5A};
        run_image(1, 0, 0, w);

        // Scenario 6: reset dominates reload, then a lone reload.
        @(negedge clk);
        reset  = 1'b1;
        reload = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        reload = 1'b0;
        check_reset_values("rst_reload");
        rand_image(5, 1);
        do_reload();
        rand_image(3, 0);

        // Full-depth image.
        do_reload();
        rand_image(DEPTH, 0);

        // Random images with random bubbles.
        for (int k = 0; k < 10; k++) begin
            do_reload();
            rand_image($urandom_range(DEPTH, 0), $urandom_range(2, 0));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Parametrised program loader replacing simulation-only memory preload in the machine top level. Receives a length-prefixed word stream over a valid/ready interface and writes it into RAM from address 0. Holds the CPU in reset with its clock gated until the image is complete, then releases it. Sits between the host/test stimulus, the ram write port and the cpu reset/clock-enable inputs.

Parameters:
ADDR_WIDTH, 8, RAM address width.
DATA_WIDTH, 8, RAM/stream word width; also the width of the length header.
MEM_DEPTH, 256, number of writable words; must be at most 2**ADDR_WIDTH.
RESET_HOLD, 4, cycles cpu_reset stays high after loading ends (minimum 1).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; restarts the loader
in_data  input  DATA_WIDTH  stream word
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a word this cycle
reload  input  1  single-cycle pulse; restarts loading from RUN
mem_addr  output  ADDR_WIDTH  RAM write address
mem_data  output  DATA_WIDTH  RAM write data
mem_we  output  1  RAM write strobe, one cycle per word
cpu_reset  output  1  reset to cpu
cpu_clk_en  output  1  enable for the system clock
busy  output  1  loader active (any state except RUN and ERR)
done  output  1  image loaded, CPU running
error  output  1  bad length header, sticky

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- All outputs are registered. Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_data 0, cpu_reset 1, cpu_clk_en 0, busy 1, done 0, error 0. State goes to LEN.
- States: LEN, LOAD, FILL (only with the optional feature), HOLD, RUN, ERR.
- Transfer: a word is taken on a rising edge where in_valid && in_ready. in_ready is 1 only in LEN and LOAD, and is 0 on the first cycle after reset.
- LEN: the accepted word is the length N.
  - N > MEM_DEPTH: go to ERR.
  - N == 0: go to FILL/HOLD with no writes.
  - Otherwise: go to LOAD with word counter = 0.
- LOAD: accepted word k (0-based) produces mem_we=1, mem_addr=k and mem_data=word in the following cycle. Write latency is 1 cycle.
  - Back-to-back acceptance at one word per cycle is supported.
  - Bubbles on in_valid insert no writes.
  - After word N-1 is accepted, in_ready drops in the next cycle and the state advances.
- HOLD: cpu_reset=1 and cpu_clk_en=0 for exactly RESET_HOLD cycles, counted from HOLD entry. Then go to RUN.
- RUN: cpu_reset=0, cpu_clk_en=1, done=1, busy=0, in_ready=0. Stream input is ignored.
- reload while in RUN: next cycle cpu_reset=1, cpu_clk_en=0, done=0, busy=1, state LEN. reload is ignored in all other states.
- ERR: error=1, in_ready=0, cpu_reset=1, cpu_clk_en=0, busy=0. Only reset leaves ERR.
- Reset asserted in any state, including mid-LOAD or mid-HOLD, aborts immediately to reset values. Already-written RAM words are not erased. Reset dominates reload.
- Address wrap cannot occur because N ≤ MEM_DEPTH ≤ 2**ADDR_WIDTH. Counters are sized ADDR_WIDTH+1 so N == MEM_DEPTH == 2**ADDR_WIDTH is representable.

Optional Feature:
BOOT_LOADER_ZERO_FILL_EN
- Defined: after LOAD (or after LEN with N=0), FILL writes 0 to addresses N..MEM_DEPTH-1, one write per cycle with in_ready=0, then goes to HOLD. If N == MEM_DEPTH, FILL is skipped.
- Undefined: the FILL state does not exist; LOAD/LEN go straight to HOLD and memory above N-1 is untouched.

Test Plan:
1. Reset, then stream 03,A1,B2,C3 with in_valid held high. Required: writes (0,A1),(1,B2),(2,C3) on consecutive cycles; cpu_reset falls exactly 4 cycles after HOLD entry; done=1; cpu_clk_en=1.
2. Stream 02,11,22 with in_valid low for 3 cycles between words. Required: exactly 2 writes; no mem_we during the bubbles; same release timing as scenario 1.
3. MEM_DEPTH=16, length header 11h. Required: error=1, in_ready=0, cpu_reset stays 1 for 50 cycles, no mem_we. After reset, error=0.
4. Length 00. Required: no writes (without zero fill), RUN reached after RESET_HOLD cycles. With BOOT_LOADER_ZERO_FILL_EN and MEM_DEPTH=16: 16 zero writes to addresses 0..F, then RUN.
5. Reset asserted after the 2nd of 4 data words. Required: next cycle in_ready=0, cpu_reset=1, state LEN. A fresh stream 01,5A writes (0,5A) and runs.
6. In RUN, pulse reload in the same cycle as reset, then separately pulse reload alone. Required: reset values first; on the lone reload, the next cycle has done=0, cpu_reset=1, in_ready=1 and awaits a new length.
